// File: rtl/knob_pkg.sv
// Shared channel identifiers, widths and MCP3008 frame constants for the pot scanner.
package knob_pkg;

  localparam int unsigned NUM_KNOBS     = 12;
  localparam int unsigned KNOB_W        = 10;
  localparam int unsigned KNOB_ID_W     = 4;
  localparam int unsigned DIFF_W        = KNOB_W + 1;
  localparam int unsigned ADC_ADDR_W    = 3;
  localparam int unsigned FRAME_PERIODS = 17;
  localparam int unsigned DATA_START    = 7;
  localparam int unsigned PERIOD_W      = 5;

  typedef enum logic [KNOB_ID_W-1:0] {
    KNOB_VOLUME           = 4'd0,
    KNOB_PITCH            = 4'd1,
    KNOB_DELAY_WET        = 4'd2,
    KNOB_DELAY_RATE       = 4'd3,
    KNOB_DELAY_FEEDBACK   = 4'd4,
    KNOB_REVERB_WET       = 4'd5,
    KNOB_REVERB_SIZE      = 4'd6,
    KNOB_REVERB_FEEDBACK  = 4'd7,
    KNOB_FILTER_QUALITY   = 4'd8,
    KNOB_FILTER_CUTOFF    = 4'd9,
    KNOB_DISTORTION_DRIVE = 4'd10,
    KNOB_CRUSH_PRESSURE   = 4'd11
  } knob_id_t;

  typedef enum logic [1:0] {
    XF_IDLE,
    XF_CS_SETUP,
    XF_SHIFT,
    XF_CS_HOLD
  } xfer_state_t;

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_XFER,
    SEQ_UPDATE
  } seq_state_t;

  // Command bit driven during a given SCLK period: start, single-ended, D2..D0, then zeros.
  function automatic logic cmd_bit(input logic [ADC_ADDR_W-1:0] addr,
                                   input logic [PERIOD_W-1:0]   period);
    case (period)
      5'd0, 5'd1: return 1'b1;
      5'd2:       return addr[2];
      5'd3:       return addr[1];
      5'd4:       return addr[0];
      default:    return 1'b0;
    endcase
  endfunction

  function automatic logic [DIFF_W-1:0] abs_diff(input logic [KNOB_W-1:0] a,
                                                 input logic [KNOB_W-1:0] b);
    if (a >= b) return DIFF_W'(a) - DIFF_W'(b);
    else        return DIFF_W'(b) - DIFF_W'(a);
  endfunction

endpackage

// File: rtl/spi_adc_xfer.sv
// One MCP3008 single-ended conversion: CS setup, 17 SCLK periods, CS hold.
module spi_adc_xfer
  import knob_pkg::*;
#(
  parameter int unsigned CLK_DIV = 50
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  chip,
  input  logic [ADC_ADDR_W-1:0] addr,
  input  logic                  miso,
  output logic                  sclk,
  output logic                  mosi,
  output logic [1:0]            cs_n,
  output logic [KNOB_W-1:0]     data,
  output logic                  done_c
);

  localparam int unsigned CNT_W = $clog2(CLK_DIV);

  xfer_state_t           state;
  logic [CNT_W-1:0]      cnt;
  logic [PERIOD_W-1:0]   period;
  logic [ADC_ADDR_W-1:0] addr_q;
  logic                  half_end_c;

  assign half_end_c = (cnt == CNT_W'(CLK_DIV - 1));
  // Asserted in the last CS_HOLD cycle so the sequencer enters UPDATE with no gap.
  assign done_c     = (state == XF_CS_HOLD) && half_end_c;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= XF_IDLE;
      cnt    <= '0;
      period <= '0;
      addr_q <= '0;
      sclk   <= 1'b0;
      mosi   <= 1'b0;
      cs_n   <= 2'b11;
      data   <= '0;
    end else begin
      case (state)
        XF_IDLE: begin
          if (start) begin
            cs_n   <= chip ? 2'b01 : 2'b10;
            addr_q <= addr;
            mosi   <= cmd_bit(addr, PERIOD_W'(0));
            period <= '0;
            cnt    <= '0;
            state  <= XF_CS_SETUP;
          end
        end
        XF_CS_SETUP: begin
          if (half_end_c) begin
            cnt   <= '0;
            state <= XF_SHIFT;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        XF_SHIFT: begin
          if (!half_end_c) begin
            cnt <= cnt + CNT_W'(1);
          end else if (!sclk) begin
            // Rising edge: capture only the ten result bits at the tail of the frame.
            cnt  <= '0;
            sclk <= 1'b1;
            if (period >= PERIOD_W'(DATA_START)) data <= {data[KNOB_W-2:0], miso};
          end else begin
            cnt  <= '0;
            sclk <= 1'b0;
            if (period == PERIOD_W'(FRAME_PERIODS - 1)) begin
              mosi  <= 1'b0;
              cs_n  <= 2'b11;
              state <= XF_CS_HOLD;
            end else begin
              period <= period + PERIOD_W'(1);
              mosi   <= cmd_bit(addr_q, period + PERIOD_W'(1));
            end
          end
        end
        XF_CS_HOLD: begin
          if (half_end_c) begin
            cnt   <= '0;
            state <= XF_IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= XF_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/pot_scanner.sv
// Round-robin scanner for twelve pots on two MCP3008s with per-channel hysteresis.
module pot_scanner
  import knob_pkg::*;
#(
  parameter int unsigned CLK_DIV = 50,
  parameter int unsigned HYST    = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              scan_en,
  output logic                              adc_sclk,
  output logic                              adc_mosi,
  input  logic                              adc_miso,
  output logic [1:0]                        adc_cs_n,
  output logic [NUM_KNOBS-1:0][KNOB_W-1:0]  knob_vals,
  output logic                              knob_valid,
  output logic                              scan_done
);

  seq_state_t             state;
  knob_id_t               k;
  logic [KNOB_ID_W-1:0]   k_raw;
  logic [NUM_KNOBS-1:0]   first;
  logic                   start_c;
  logic                   chip_c;
  logic                   done_c;
  logic [KNOB_W-1:0]      result;
  logic [DIFF_W-1:0]      diff_c;

  assign k_raw   = k;
  assign start_c = (state == SEQ_IDLE) && scan_en;
  assign chip_c  = (k_raw >= KNOB_ID_W'(8));
  assign diff_c  = abs_diff(result, knob_vals[k]);

  spi_adc_xfer #(
    .CLK_DIV (CLK_DIV)
  ) u_xfer (
    .clk    (clk),
    .rst    (rst),
    .start  (start_c),
    .chip   (chip_c),
    .addr   (k_raw[ADC_ADDR_W-1:0]),
    .miso   (adc_miso),
    .sclk   (adc_sclk),
    .mosi   (adc_mosi),
    .cs_n   (adc_cs_n),
    .data   (result),
    .done_c (done_c)
  );

  // Channel sequencer; output values only move in UPDATE so downstream sampling sees stable data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= SEQ_IDLE;
      k          <= KNOB_VOLUME;
      first      <= '1;
      knob_vals  <= '0;
      knob_valid <= 1'b0;
      scan_done  <= 1'b0;
    end else begin
      scan_done <= 1'b0;
      case (state)
        SEQ_IDLE: begin
          if (scan_en) state <= SEQ_XFER;
        end
        SEQ_XFER: begin
          if (done_c) state <= SEQ_UPDATE;
        end
        SEQ_UPDATE: begin
          if (first[k] || (diff_c >= DIFF_W'(HYST))) begin
            knob_vals[k] <= result;
            first[k]     <= 1'b0;
          end
          if (k == KNOB_CRUSH_PRESSURE) begin
            k          <= KNOB_VOLUME;
            scan_done  <= 1'b1;
            knob_valid <= 1'b1;
          end else begin
            k <= knob_id_t'(k_raw + KNOB_ID_W'(1));
          end
          state <= SEQ_IDLE;
        end
        default: state <= SEQ_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pot_scanner.sv
// Directed bench for pot_scanner with a behavioural dual-MCP3008 on the shared SPI bus.
module tb_pot_scanner;
  import knob_pkg::*;

  localparam int unsigned CLK_DIV = 2;
  localparam int unsigned HYST    = 4;

  logic                             clk = 1'b0;
  logic                             rst = 1'b1;
  logic                             scan_en = 1'b0;
  logic                             adc_sclk, adc_mosi, adc_miso;
  logic [1:0]                       adc_cs_n;
  logic [NUM_KNOBS-1:0][KNOB_W-1:0] knob_vals;
  logic                             knob_valid, scan_done;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pot_scanner #(.CLK_DIV(CLK_DIV), .HYST(HYST)) dut (
    .clk        (clk),
    .rst        (rst),
    .scan_en    (scan_en),
    .adc_sclk   (adc_sclk),
    .adc_mosi   (adc_mosi),
    .adc_miso   (adc_miso),
    .adc_cs_n   (adc_cs_n),
    .knob_vals  (knob_vals),
    .knob_valid (knob_valid),
    .scan_done  (scan_done)
  );

  // ADC model state and bus monitors, all updated on the falling clk edge.
  logic [KNOB_W-1:0] model_val [16];
  logic              miso_q = 1'b0;
  logic [4:0]        cmd = '0;
  logic [4:0]        ch9_cmd = '0;
  logic [1:0]        cs_prev = 2'b11;
  logic              sclk_prev = 1'b0, mosi_prev = 1'b0, done_prev = 1'b0;
  int cyc = 0;
  int rises = 0, cur_ch = 0, mdl_ch = -1;
  int fall_cyc = -1, cs_low_len = 0, fall_period = 0, txn_len = 0;
  int cs_falls = 0, overlap = 0, mosi_viol = 0;

  assign adc_miso = miso_q;

  always @(posedge clk) cyc <= cyc + 1;

  initial forever begin
    @(negedge clk);
    if (adc_cs_n == 2'b00) overlap++;
    if (adc_mosi !== mosi_prev && adc_sclk) mosi_viol++;
    if (cs_prev == 2'b11 && adc_cs_n != 2'b11) begin
      if (fall_cyc >= 0) fall_period = cyc - fall_cyc;
      fall_cyc = cyc;
      cs_falls++;
      rises = 0;
      cmd = '0;
      mdl_ch = -1;
      miso_q = 1'b0;
    end
    if (cs_prev != 2'b11 && adc_cs_n == 2'b11) cs_low_len = cyc - fall_cyc;
    if (adc_cs_n != 2'b11) begin
      if (adc_sclk && !sclk_prev) begin
        if (rises < 5) cmd = {cmd[3:0], adc_mosi};
        rises++;
        if (rises == 5) begin
          cur_ch = int'(cmd[2:0]) + (adc_cs_n[1] ? 0 : 8);
          mdl_ch = cur_ch;
          if (cur_ch == 9) ch9_cmd = cmd;
        end
      end else if (!adc_sclk && sclk_prev) begin
        if (rises >= 7 && rises <= 16) miso_q = model_val[cur_ch][16 - rises];
        else miso_q = 1'b0;
      end
    end
    if (scan_done && !done_prev) txn_len = cyc - fall_cyc;
    cs_prev   = adc_cs_n;
    sclk_prev = adc_sclk;
    mosi_prev = adc_mosi;
    done_prev = scan_done;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_done();
    bit ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      tick();
      if (scan_done) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      tests++; fails++;
      $display("FAIL scan_done_timeout: none within 2000 cycles");
    end
  endtask

  task automatic wait_txn_end(output int ch);
    logic [1:0] prev = adc_cs_n;
    bit ok = 1'b0;
    ch = -1;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (prev != 2'b11 && adc_cs_n == 2'b11) begin ok = 1'b1; ch = mdl_ch; break; end
      prev = adc_cs_n;
    end
    if (!ok) begin
      tests++; fails++;
      $display("FAIL txn_end_timeout: CS_n never returned high within 300 cycles");
    end
  endtask

  task automatic wait_ch_end(input int tgt);
    int ch;
    for (int i = 0; i < 14; i++) begin
      wait_txn_end(ch);
      if (ch == tgt) return;
    end
    tests++; fails++;
    $display("FAIL ch_end_timeout: channel %0d transaction not seen", tgt);
  endtask

  task automatic wait_in_txn(input int tgt);
    for (int i = 0; i < 2000; i++) begin
      tick();
      if (mdl_ch == tgt && adc_cs_n != 2'b11) return;
    end
    tests++; fails++;
    $display("FAIL in_txn_timeout: channel %0d never addressed", tgt);
  endtask

  task automatic test_reset();
    for (int i = 0; i < NUM_KNOBS; i++) model_val[i] = KNOB_W'(64 * i + 5);
    for (int i = NUM_KNOBS; i < 16; i++) model_val[i] = '0;
    #2 rst = 1'b0;
    tick(); tick();
    tests += 6;
    if (adc_cs_n !== 2'b11) begin fails++; $display("FAIL reset_cs_n: got %b want 11", adc_cs_n); end
    if (adc_sclk !== 1'b0) begin fails++; $display("FAIL reset_sclk: got %b want 0", adc_sclk); end
    if (adc_mosi !== 1'b0) begin fails++; $display("FAIL reset_mosi: got %b want 0", adc_mosi); end
    if (knob_vals !== '0) begin fails++; $display("FAIL reset_vals: got %h want 0", knob_vals); end
    if (knob_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", knob_valid); end
    if (scan_done !== 1'b0) begin fails++; $display("FAIL reset_scan_done: got %b want 0", scan_done); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_first_scan();
    bit early = 1'b0;
    bit seen = 1'b0;
    scan_en = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      tick();
      if (scan_done) begin seen = 1'b1; break; end
      if (knob_valid) early = 1'b1;
    end
    tests += 4;
    if (!seen) begin fails++; $display("FAIL first_scan_done: got none want pulse within 2000 cycles"); end
    if (early) begin fails++; $display("FAIL valid_early: got 1 before scan_done want 0"); end
    if (knob_valid !== 1'b1) begin fails++; $display("FAIL valid_with_done: got %b want 1", knob_valid); end
    tick();
    if (scan_done !== 1'b0) begin fails++; $display("FAIL done_width: got %b want 0 on second cycle", scan_done); end
    for (int i = 0; i < NUM_KNOBS; i++) begin
      tests++;
      if (knob_vals[i] !== KNOB_W'(64 * i + 5)) begin
        fails++;
        $display("FAIL first_scan_ch%0d: got %0d want %0d", i, knob_vals[i], 64 * i + 5);
      end
    end
  endtask

  task automatic test_timing();
    // CS low = setup + 17 periods (35*CLK_DIV); a transaction is 36*CLK_DIV+1 plus one IDLE cycle between.
    tests += 6;
    if (txn_len != 73) begin fails++; $display("FAIL txn_len: got %0d want 73", txn_len); end
    if (cs_low_len != 70) begin fails++; $display("FAIL cs_low_len: got %0d want 70", cs_low_len); end
    if (fall_period != 74) begin fails++; $display("FAIL txn_period: got %0d want 74", fall_period); end
    if (overlap != 0) begin fails++; $display("FAIL cs_overlap: got %0d cycles want 0", overlap); end
    if (mosi_viol != 0) begin fails++; $display("FAIL mosi_while_high: got %0d want 0", mosi_viol); end
    if (ch9_cmd !== 5'b11001) begin fails++; $display("FAIL ch9_mosi: got %b want 11001", ch9_cmd); end
  endtask

  task automatic test_hysteresis();
    wait_done();
    model_val[0] = 10'd500;
    wait_ch_end(0);
    tick(); tick();
    tests += 2;
    if (knob_vals[0] !== 10'd5) begin fails++; $display("FAIL hyst_500_before: got %0d want 5", knob_vals[0]); end
    tick();
    if (knob_vals[0] !== 10'd500) begin fails++; $display("FAIL hyst_500: got %0d want 500", knob_vals[0]); end
    wait_done();
    model_val[0] = 10'd502;
    wait_ch_end(0);
    tick(); tick(); tick();
    tests++;
    if (knob_vals[0] !== 10'd500) begin fails++; $display("FAIL hyst_502_hold: got %0d want 500", knob_vals[0]); end
    wait_done();
    model_val[0] = 10'd504;
    wait_ch_end(0);
    tick(); tick();
    tests += 2;
    if (knob_vals[0] !== 10'd500) begin fails++; $display("FAIL hyst_504_before: got %0d want 500", knob_vals[0]); end
    tick();
    if (knob_vals[0] !== 10'd504) begin fails++; $display("FAIL hyst_504: got %0d want 504", knob_vals[0]); end
  endtask

  task automatic test_boundary();
    wait_done();
    model_val[0]  = 10'd1023;
    model_val[11] = 10'd0;
    wait_done();
    tests += 3;
    if (knob_vals[0] !== 10'd1023) begin fails++; $display("FAIL bound_k0_1023: got %0d want 1023", knob_vals[0]); end
    if (knob_vals[11] !== 10'd0) begin fails++; $display("FAIL bound_k11_0: got %0d want 0", knob_vals[11]); end
    if (knob_vals[10] !== 10'd645) begin fails++; $display("FAIL bound_k10: got %0d want 645", knob_vals[10]); end
    model_val[0] = 10'd0;
    wait_ch_end(0);
    tick(); tick(); tick();
    tests++;
    if (knob_vals[0] !== 10'd0) begin fails++; $display("FAIL bound_1023_to_0: got %0d want 0", knob_vals[0]); end
  endtask

  task automatic test_reset_mid();
    int ch;
    model_val[0] = 10'd2;
    model_val[3] = 10'd777;
    wait_in_txn(5);
    tick(); tick(); tick();
    rst = 1'b0;
    #1;
    tests += 6;
    if (adc_cs_n !== 2'b11) begin fails++; $display("FAIL mid_rst_cs_n: got %b want 11", adc_cs_n); end
    if (adc_sclk !== 1'b0) begin fails++; $display("FAIL mid_rst_sclk: got %b want 0", adc_sclk); end
    if (adc_mosi !== 1'b0) begin fails++; $display("FAIL mid_rst_mosi: got %b want 0", adc_mosi); end
    if (knob_vals !== '0) begin fails++; $display("FAIL mid_rst_vals: got %h want 0", knob_vals); end
    if (knob_valid !== 1'b0) begin fails++; $display("FAIL mid_rst_valid: got %b want 0", knob_valid); end
    if (scan_done !== 1'b0) begin fails++; $display("FAIL mid_rst_done: got %b want 0", scan_done); end
    tick(); tick();
    rst = 1'b1;
    wait_txn_end(ch);
    tick(); tick(); tick();
    tests += 2;
    if (ch != 0) begin fails++; $display("FAIL mid_rst_restart: got channel %0d want 0", ch); end
    // Value 2 is below HYST, so it only loads if the first-sample flag was restored.
    if (knob_vals[0] !== 10'd2) begin fails++; $display("FAIL mid_rst_first_sample: got %0d want 2", knob_vals[0]); end
  endtask

  task automatic test_scan_en_drop();
    int ch;
    int falls;
    wait_in_txn(3);
    scan_en = 1'b0;
    wait_txn_end(ch);
    tick(); tick(); tick();
    tests += 3;
    if (ch != 3) begin fails++; $display("FAIL drop_completes: got channel %0d want 3", ch); end
    if (knob_vals[3] !== 10'd777) begin fails++; $display("FAIL drop_k3_update: got %0d want 777", knob_vals[3]); end
    if (knob_vals[2] !== 10'd133) begin fails++; $display("FAIL drop_k2: got %0d want 133", knob_vals[2]); end
    falls = cs_falls;
    for (int i = 0; i < 200; i++) tick();
    tests += 3;
    if (cs_falls != falls) begin fails++; $display("FAIL drop_idle_cs: got %0d new CS falls want 0", cs_falls - falls); end
    if (adc_cs_n !== 2'b11) begin fails++; $display("FAIL drop_idle_cs_n: got %b want 11", adc_cs_n); end
    if (knob_vals[4] !== 10'd0) begin fails++; $display("FAIL drop_k4_idle: got %0d want 0", knob_vals[4]); end
    scan_en = 1'b1;
    wait_txn_end(ch);
    tick(); tick(); tick();
    tests += 2;
    if (ch != 4) begin fails++; $display("FAIL resume_ch: got channel %0d want 4", ch); end
    if (knob_vals[4] !== 10'd261) begin fails++; $display("FAIL resume_k4: got %0d want 261", knob_vals[4]); end
    tests++;
    if (overlap != 0) begin fails++; $display("FAIL cs_overlap_end: got %0d cycles want 0", overlap); end
  endtask

  initial begin
    test_reset();
    test_first_scan();
    test_timing();
    test_hysteresis();
    test_boundary();
    test_reset_mid();
    test_scan_en_drop();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
